// File: rtl/instr_sequencer.sv
// Instruction fetch/execute sequencer: paces fetch, execute, output handshake and halt,
// and counts completed instructions.
module instr_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [7:0]  ir,
    input  logic        outReady,
    output logic        loadIR,
    output logic        pcInc,
    output logic        execEnable,
    output logic        outValid,
    output logic        halted,
    output logic [1:0]  phase,
    output logic [15:0] instrCount
);

    localparam int unsigned CountWidth = 16;
    localparam logic [2:0]  DestOut    = 3'b110;
    localparam logic [2:0]  DestHalt   = 3'b111;

    typedef enum logic [1:0] {
        FETCH    = 2'b00,
        EXEC     = 2'b01,
        WAIT_OUT = 2'b10,
        HALT     = 2'b11
    } stateT;

    stateT                 state;
    stateT                 nextState;
    logic [CountWidth-1:0] countQ;
    logic [2:0]            dest;
    logic                  srcRom;
    logic                  unusedIr;

    assign dest     = ir[6:4];
    assign srcRom   = (ir[2:0] == 3'b000);
    // Flag bits 7 and 3 carry no meaning for sequencing.
    assign unusedIr = ^{ir[7], ir[3]};

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; run is only consulted in FETCH
    always_comb begin
        nextState = state;
        unique case (state)
            FETCH: begin
                if (run) begin
                    nextState = EXEC;
                end
            end
            EXEC: begin
                if (dest == DestHalt) begin
                    nextState = HALT;
                end else if (dest == DestOut && !outReady) begin
                    nextState = WAIT_OUT;
                end else begin
                    nextState = FETCH;
                end
            end
            WAIT_OUT: begin
                if (outReady) begin
                    nextState = FETCH;
                end
            end
            HALT: begin
                nextState = HALT;
            end
            default: begin
                nextState = FETCH;
            end
        endcase
    end

    // Output decode; strobes are forced low while reset is asserted
    always_comb begin
        loadIR     = 1'b0;
        pcInc      = 1'b0;
        execEnable = 1'b0;
        outValid   = 1'b0;
        halted     = 1'b0;
        if (!reset) begin
            unique case (state)
                FETCH: begin
                    loadIR = run;
                    pcInc  = run;
                end
                EXEC: begin
                    if (dest != DestHalt) begin
                        outValid = (dest == DestOut);
                        if (dest != DestOut || outReady) begin
                            execEnable = 1'b1;
                            pcInc      = srcRom;
                        end
                    end
                end
                WAIT_OUT: begin
                    outValid = 1'b1;
                    if (outReady) begin
                        execEnable = 1'b1;
                        pcInc      = srcRom;
                    end
                end
                HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    halted = 1'b0;
                end
            endcase
        end
    end

    assign phase = state;

    // Completed-instruction counter, wraps silently
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            countQ <= '0;
        end else if (execEnable) begin
            countQ <= countQ + CountWidth'(1);
        end
    end

    assign instrCount = countQ;

endmodule
